// File: rtl/seq_pattern_fsm.sv
// ---------------------------------------------------------------------------
// seq_pattern_fsm
//   Serial sequence detector for a PATTERN_W-bit pattern. The pattern can be
//   reloaded at run time. The first bit received is compared against the MSB.
//   Only bits with in_valid=1 are shifted in. Each completed match produces a
//   registered one-cycle pulse on out.
//
//   OVERLAP=1 keeps the history after a match, so a trailing part of one match
//   can start the next. OVERLAP=0 clears the history after a match, so the
//   next match needs PATTERN_W fresh bits.
//
//   Optional feature: define SEQ_MATCH_CNT_EN to add a saturating match
//   counter on port match_cnt. Without the macro, the port and the counter
//   are absent.
// ---------------------------------------------------------------------------
module seq_pattern_fsm #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
  output logic                 out,
  output logic                 filled
`ifdef SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]     match_cnt
`endif
);

  // The fill counter has to hold the value PATTERN_W itself.
  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  typedef enum logic {
    FILL   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [PATTERN_W-1:0]   history_reg;
  logic [PATTERN_W-1:0]   pattern_reg;
  logic [FILL_W-1:0]      fill_cnt_reg;
  logic                   out_reg;
  logic                   filled_reg;

  logic [PATTERN_W-1:0]   hist_shift;
  logic [FILL_W-1:0]      fill_cnt_next;
  logic [PATTERN_W-1:0]   bit_eq;
  logic                   match_now;

  // History as it would look after the current bit is accepted.
  assign hist_shift    = {history_reg[PATTERN_W-2:0], in};
  assign fill_cnt_next = fill_cnt_reg + FILL_W'(1);

  // Per-bit equality between the shifted history and the active pattern.
  for (genvar gi = 0; gi < PATTERN_W; gi++) begin : g_cmp
    assign bit_eq[gi] = ~(hist_shift[gi] ^ pattern_reg[gi]);
  end

  assign match_now = &bit_eq;

  // Detector FSM. Priority is reset, then pattern load, then an accepted bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FILL;
      history_reg  <= '0;
      pattern_reg  <= PATTERN;
      fill_cnt_reg <= '0;
      out_reg      <= 1'b0;
      filled_reg   <= 1'b0;
    end else if (pat_load) begin
      // A new pattern abandons any partial match. The bit on this edge is dropped.
      state_reg    <= FILL;
      history_reg  <= '0;
      pattern_reg  <= pat_in;
      fill_cnt_reg <= '0;
      out_reg      <= 1'b0;
      filled_reg   <= 1'b0;
    end else if (in_valid) begin
      history_reg <= hist_shift;
      out_reg     <= 1'b0;
      case (state_reg)
        FILL: begin
          fill_cnt_reg <= fill_cnt_next;
          if (fill_cnt_next == FILL_FULL) begin
            // The history becomes full on this edge and is compared right away.
            if (match_now && !OVERLAP) begin
              state_reg    <= FILL;
              history_reg  <= '0;
              fill_cnt_reg <= '0;
              filled_reg   <= 1'b0;
            end else begin
              state_reg  <= SEARCH;
              filled_reg <= 1'b1;
            end
            out_reg <= match_now;
          end
        end
        SEARCH: begin
          out_reg <= match_now;
          if (match_now && !OVERLAP) begin
            state_reg    <= FILL;
            history_reg  <= '0;
            fill_cnt_reg <= '0;
            filled_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg    <= FILL;
          history_reg  <= '0;
          fill_cnt_reg <= '0;
          filled_reg   <= 1'b0;
        end
      endcase
    end else begin
      // No bit accepted: hold all state. A pulse lasts only one cycle.
      out_reg <= 1'b0;
    end
  end

  assign out    = out_reg;
  assign filled = filled_reg;

`ifdef SEQ_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] match_cnt_reg;
  logic             pulse_set;

  // Edges that will raise out on the next cycle.
  assign pulse_set = in_valid && match_now &&
                     ((state_reg == SEARCH) ||
                      ((state_reg == FILL) && (fill_cnt_next == FILL_FULL)));

  // Saturating count of match pulses. It is cleared when a new pattern is loaded.
  always_ff @(posedge clk) begin
    if (reset || pat_load) begin
      match_cnt_reg <= '0;
    end else if (pulse_set && (match_cnt_reg != CNT_MAX)) begin
      match_cnt_reg <= match_cnt_reg + CNT_W'(1);
    end
  end

  assign match_cnt = match_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_fsm
//   Drives two detectors in parallel: one with overlapping matches and one
//   without. Both receive the same stream. A queue-based model predicts
//   out/filled (and match_cnt when SEQ_MATCH_CNT_EN is defined), and the
//   outputs are compared on every falling edge. Directed streams pin the
//   model with literal values, then a randomized stream follows.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_pattern_fsm;

  localparam int         W    = 4;
  localparam logic [3:0] PDEF = 4'b1011;
  localparam int         CW   = 8;

  logic         clk = 1'b0;
  logic         reset, in, in_valid, pat_load;
  logic [W-1:0] pat_in;
  logic         out_a, filled_a, out_b, filled_b;
`ifdef SEQ_MATCH_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  seq_pattern_fsm #(.PATTERN_W(W), .PATTERN(PDEF), .OVERLAP(1'b1), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .out(out_a), .filled(filled_a)
`ifdef SEQ_MATCH_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  seq_pattern_fsm #(.PATTERN_W(W), .PATTERN(PDEF), .OVERLAP(1'b0), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .out(out_b), .filled(filled_b)
`ifdef SEQ_MATCH_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: accepted bits since the last clear (oldest first).
  bit           q_a[$];
  bit           q_b[$];
  logic [W-1:0] pat_m;
  logic         exp_out_a, exp_out_b;
  int           cnt_m_a, cnt_m_b;
  bit           cmp_en = 1'b0;
  int           txn = 0;

  function automatic logic [W-1:0] q_value(input bit q[$]);
    logic [W-1:0] v = '0;
    foreach (q[i]) v = {v[W-2:0], q[i]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at txn %0d: got %0h expected %0h", name, txn, act, exp);
    end
  endtask

  // Model update for one clock edge.
  task automatic model_edge(input logic r, input logic v, input logic b,
                            input logic l, input logic [W-1:0] p);
    exp_out_a = 1'b0;
    exp_out_b = 1'b0;
    if (r || l) begin
      q_a.delete();
      q_b.delete();
      pat_m   = r ? PDEF : p;
      cnt_m_a = 0;
      cnt_m_b = 0;
    end else if (v) begin
      q_a.push_back(b);
      if (q_a.size() > W) void'(q_a.pop_front());
      q_b.push_back(b);
      if (q_b.size() > W) void'(q_b.pop_front());
      if (q_a.size() == W && q_value(q_a) == pat_m) begin
        exp_out_a = 1'b1;
        if (cnt_m_a < (1 << CW) - 1) cnt_m_a++;
      end
      if (q_b.size() == W && q_value(q_b) == pat_m) begin
        exp_out_b = 1'b1;
        if (cnt_m_b < (1 << CW) - 1) cnt_m_b++;
        q_b.delete();
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b,
                      input logic l, input logic [W-1:0] p);
    reset = r; in_valid = v; in = b; pat_load = l; pat_in = p;
    @(posedge clk);
    model_edge(r, v, b, l, p);
    if (r) cmp_en = 1'b1;
    txn++;
    #1;
    $display("txn %0d rst=%b v=%b in=%b ld=%b pat=%b | a: out=%b filled=%b  b: out=%b filled=%b",
             txn, r, v, b, l, p, out_a, filled_a, out_b, filled_b);
  endtask

  task automatic bits(input int n, input logic [31:0] s);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, s[i], 1'b0, '0);
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_a",    32'(out_a),    32'(exp_out_a));
      check("filled_a", 32'(filled_a), 32'(q_a.size() == W));
      check("out_b",    32'(out_b),    32'(exp_out_b));
      check("filled_b", 32'(filled_b), 32'(q_b.size() == W));
`ifdef SEQ_MATCH_CNT_EN
      check("cnt_a", 32'(cnt_a), 32'(cnt_m_a));
      check("cnt_b", 32'(cnt_b), 32'(cnt_m_b));
`endif
    end
  end

  initial begin
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = '0;

    // Scenario 1/2: reset, then 1011011.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("rst_out",    32'({out_a, out_b}),       32'd0);
    check("rst_filled", 32'({filled_a, filled_b}), 32'd0);
    bits(3, 32'b101);
    check("pre4_out", 32'(out_a), 32'd0);
    bits(1, 32'b1);
    check("bit4_out_a",    32'(out_a),    32'd1);
    check("bit4_filled_a", 32'(filled_a), 32'd1);
    check("bit4_out_b",    32'(out_b),    32'd1);
    check("bit4_filled_b", 32'(filled_b), 32'd0);
    bits(3, 32'b011);
    check("bit7_out_a", 32'(out_a), 32'd1);
    check("bit7_out_b", 32'(out_b), 32'd0);

    // Scenario 3: gap of invalid cycles within the pattern.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    bits(3, 32'b101);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("gap_out", 32'(out_a), 32'd0);
    end
    bits(1, 32'b1);
    check("gap_match", 32'({out_a, out_b}), 32'b11);

    // Scenario 4: load 0110 after two bits.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    bits(2, 32'b10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    check("load_filled", 32'(filled_a), 32'd0);
    bits(4, 32'b0110);
    check("load_match", 32'({out_a, out_b}), 32'b11);
    bits(4, 32'b1011);
    check("load_old_pat", 32'({out_a, out_b}), 32'b00);

    // Scenario 5: reset on the edge of the fourth bit.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    bits(3, 32'b101);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("rst4_out",    32'({out_a, out_b}),       32'd0);
    check("rst4_filled", 32'({filled_a, filled_b}), 32'd0);

    // Randomized stream with occasional reloads and resets.
    for (int n = 0; n < 2000; n++) begin
      logic r, v, b, l;
      logic [W-1:0] p;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom);
      p = ($urandom_range(0, 1) == 0) ? PDEF : W'($urandom);
      step(r, v, b, l, p);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
